// File: rtl/spart_pkg.sv
// spart_pkg: shared SPART state enum, bus address map and frame constants.
// The PARITY state and 11-bit frame exist only when SPART_TX_PARITY_EN is defined.
package spart_pkg;
    localparam logic [1:0] ADDR_TXBUF = 2'b00;
    localparam logic [1:0] ADDR_DIVLO = 2'b10;
    localparam logic [1:0] ADDR_DIVHI = 2'b11;
    localparam int DATA_BITS = 8;
`ifdef SPART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
`else
    localparam int FRAME_BITS = 10;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} tx_state_e;
`endif
endpackage

// File: rtl/spart_baud_gen.sv
// spart_baud_gen: reloadable baud down-counter; tick marks the last cycle of a bit period.
module spart_baud_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] div,
    input  logic        reload,
    output logic        tick
);
    logic [15:0] cnt_q, cnt_d;
    always_comb cnt_d = reload ? div : (cnt_q == 16'd0 ? cnt_q : cnt_q - 16'd1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= 16'd0;
        else cnt_q <= cnt_d;
    end
    assign tick = cnt_q == 16'd0;
endmodule

// File: rtl/spart_tx.sv
// spart_tx: SPART transmitter with holding register, programmable divisor and 8N1 framing.
// Define SPART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module spart_tx
    import spart_pkg::*;
#(
    parameter logic [15:0] DEFAULT_DIV = 16'd325
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       iocs,
    input  logic       iorw,
    input  logic [1:0] ioaddr,
    input  logic [7:0] wdata,
    output logic       tbr,
    output logic       txd
);
    tx_state_e   state_q, state_d;
    logic [7:0]  hold_q, hold_d, shift_q, shift_d;
    logic [15:0] div_q, div_d;
    logic [2:0]  idx_q, idx_d;
    logic        tbr_q, tbr_d;
    logic        wr, acc, load, reload, tick, last, bit_end;
`ifdef SPART_TX_PARITY_EN
    logic        par_q, par_d;
`endif
    assign wr      = iocs && !iorw;
    assign load    = !tbr_q && (state_q == IDLE || (state_q == STOP && tick));
    // a buffer write on the edge the holding register drains is still accepted
    assign acc     = wr && ioaddr == ADDR_TXBUF && (tbr_q || load);
    assign last    = idx_q == 3'(DATA_BITS - 1);
    assign bit_end = state_q == DATA && tick;
    assign reload  = load || (state_q != IDLE && tick);
    assign tbr     = tbr_q;
    spart_baud_gen u_baud (
        .clk    (clk),
        .rst    (rst),
        .div    (div_q),
        .reload (reload),
        .tick   (tick)
    );
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = load ? START : IDLE;
            START:   state_d = tick ? DATA : START;
`ifdef SPART_TX_PARITY_EN
            DATA:    state_d = tick && last ? PARITY : DATA;
            PARITY:  state_d = tick ? STOP : PARITY;
`else
            DATA:    state_d = tick && last ? STOP : DATA;
`endif
            STOP:    state_d = tick ? (load ? START : IDLE) : STOP;
            default: state_d = IDLE;
        endcase
    end
    always_comb begin
        txd = 1'b1;
        case (state_q)
            START:   txd = 1'b0;
            DATA:    txd = shift_q[0];
`ifdef SPART_TX_PARITY_EN
            PARITY:  txd = par_q;
`endif
            default: txd = 1'b1;
        endcase
    end
    always_comb begin
        hold_d  = acc ? wdata : hold_q;
        tbr_d   = acc ? 1'b0 : (load ? 1'b1 : tbr_q);
        shift_d = load ? hold_q : (bit_end ? {1'b0, shift_q[7:1]} : shift_q);
        idx_d   = load ? 3'd0 : (bit_end ? idx_q + 3'd1 : idx_q);
        div_d   = !wr ? div_q :
                  ioaddr == ADDR_DIVLO ? {div_q[15:8], wdata} :
                  ioaddr == ADDR_DIVHI ? {wdata, div_q[7:0]} : div_q;
    end
`ifdef SPART_TX_PARITY_EN
    always_comb par_d = load ? ^hold_q : par_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_q <= 1'b0;
        else par_q <= par_d;
    end
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q  <= 8'd0;
            shift_q <= 8'd0;
            tbr_q   <= 1'b1;
            idx_q   <= 3'd0;
            div_q   <= DEFAULT_DIV;
        end else begin
            hold_q  <= hold_d;
            shift_q <= shift_d;
            tbr_q   <= tbr_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
        end
    end
endmodule

// File: doc/spart_tx.md
SPART_TX -- requirements
Module: spart_tx

Interface
REQ-001 Parameter DEFAULT_DIV, 16'd325, baud divisor loaded at reset; bit period = divisor+1 clk cycles.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 iocs  input  1  chip select from the bus driver; high qualifies a bus access.
REQ-005 iorw  input  1  1 = read, 0 = write; this block acts only on writes.
REQ-006 ioaddr  input  2  00 = transmit buffer, 10 = divisor low byte, 11 = divisor high byte, 01 = ignored.
REQ-007 wdata  input  8  write data, already resolved from the tristate databus upstream.
REQ-008 tbr  output  1  transmit buffer ready; high when the holding register is empty.
REQ-009 txd  output  1  serial line out, idle high, 8 data bits LSB first.

Function
REQ-010 A write strobe is iocs=1 and iorw=0, sampled on a rising clk edge.
REQ-011 A write to ioaddr 00 while tbr=1 shall load the holding register and drive tbr low from that edge.
REQ-012 A write to ioaddr 00 while tbr=0 shall be dropped; holding-register contents and tbr are unchanged.
REQ-013 Writes to 10/11 shall update the corresponding divisor byte on that edge; the new value applies at the next baud-counter reload.
REQ-014 The FSM states shall be IDLE, START, DATA, (PARITY), STOP.
REQ-015 IDLE with holding full: on the next edge, copy holding into the shift register, set tbr=1, enter START, reload the baud counter.
REQ-016 START drives txd=0 for one bit period, then enters DATA with bit index 0.
REQ-017 DATA drives shift[0]; at each bit end shift right and increment a 3-bit index; after index 7 enter PARITY (if enabled) or STOP.
REQ-018 STOP drives txd=1 for one bit period, then enters START directly if holding is full, otherwise IDLE.
REQ-019 Baud counter: 16-bit down-counter loaded with divisor at state entry; bit end when it reads 0; divisor 0 gives a 1-cycle bit.
REQ-020 Write to 00 on the same edge the holding register empties (REQ-015) shall be accepted; tbr stays low.
REQ-021 Latency: write on edge N gives txd low from edge N+1 when IDLE; a full frame is 10 bit periods (11 with parity).

Reset
REQ-022 On rst: state IDLE, txd=1, tbr=1, holding and shift registers 0, bit index 0, divisor DEFAULT_DIV, baud counter 0.
REQ-023 Reset mid-frame shall abort immediately and return txd high asynchronously; no partial frame resumes.

Configuration
REQ-024 Macro SPART_TX_PARITY_EN defined: PARITY state inserted after DATA, txd = even parity (XOR of 8 data bits) for one bit period.
REQ-025 Macro undefined: no PARITY state or parity logic; DATA goes straight to STOP.

Structure
REQ-026 Shared package spart_pkg holds the state enum, ioaddr encodings (ADDR_TXBUF, ADDR_DIVLO, ADDR_DIVHI) and frame-length constants.
REQ-027 Baud counter shall be a sub-module spart_baud_gen (divisor, reload, bit-end tick) shareable with the receive side.

Verification
REQ-028 DEFAULT_DIV=3, write 0xA5 to 00 -> txd 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; tbr low 1 cycle then high.
REQ-029 Write 0x11 then 0x22 back to back while busy -> both frames sent contiguously, STOP of first followed directly by START of second.
REQ-030 Third write while tbr=0 -> dropped; only two frames on txd.
REQ-031 Write 0x00 to 10 and 0x00 to 11 mid-frame -> current bit keeps old length; subsequent bits are 1 cycle each.
REQ-032 Assert rst during DATA bit 4 -> txd=1 and tbr=1 immediately; no further transitions until next write.
REQ-033 With SPART_TX_PARITY_EN, write 0x07 -> parity bit 1 between bit 7 and stop; frame 11 bit periods.
